// File: rtl/decode_queue_pkg.sv
// decode_queue_pkg: internal opcode codes, RV32I opcodes and the decoded bundle type
package decode_queue_pkg;
  localparam int INST_W = 6;
  localparam int REG_W = 5;
  typedef logic [INST_W-1:0] inst_t;
  // funct3-indexed families sit on 8-aligned bases so the code is base | funct3
  localparam inst_t INST_ILLEGAL = 6'd0;
  localparam inst_t INST_LUI = 6'd1;
  localparam inst_t INST_AUIPC = 6'd2;
  localparam inst_t INST_JAL = 6'd3;
  localparam inst_t INST_JALR = 6'd4;
  localparam inst_t INST_BEQ = 6'd8;
  localparam inst_t INST_LB = 6'd16;
  localparam inst_t INST_SB = 6'd24;
  localparam inst_t INST_ADDI = 6'd32;
  localparam inst_t INST_SRAI = 6'd40;
  localparam inst_t INST_ADD = 6'd48;
  localparam inst_t INST_SUB = 6'd56;
  localparam inst_t INST_SRA = 6'd57;
  localparam logic [6:0] OPC_LUI = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_JAL = 7'b1101111;
  localparam logic [6:0] OPC_JALR = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_OP = 7'b0110011;
  typedef struct packed {
    inst_t inst;
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
    logic rs1_need;
    logic rs2_need;
    logic rd_need;
    logic mem_need;
    logic [31:0] imm;
    logic illegal;
  } dec_t;
endpackage

// File: rtl/decode_queue_core.sv
// decode_core: combinational RV32I decoder producing one decoded bundle plus illegal flag
module decode_core
  import decode_queue_pkg::*;
(
  input  logic [31:0] up_inst,
  output dec_t        dec
);
  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic [31:0] i_imm, s_imm, b_imm, u_imm, j_imm;
  logic alt, ok;
  inst_t fam;
  dec_t d;
  assign opc = up_inst[6:0];
  assign f3 = up_inst[14:12];
  assign f7 = up_inst[31:25];
  assign fam = inst_t'(f3);
  assign alt = f7 == 7'h20;
  assign i_imm = {{20{up_inst[31]}}, up_inst[31:20]};
  assign s_imm = {{20{up_inst[31]}}, up_inst[31:25], up_inst[11:7]};
  assign b_imm = {{19{up_inst[31]}}, up_inst[31], up_inst[7], up_inst[30:25], up_inst[11:8], 1'b0};
  assign u_imm = {up_inst[31:12], 12'b0};
  assign j_imm = {{11{up_inst[31]}}, up_inst[31], up_inst[19:12], up_inst[20], up_inst[30:21], 1'b0};
  always_comb begin
    d = '0;
    d.rd = up_inst[11:7];
    d.rs1 = up_inst[19:15];
    d.rs2 = up_inst[24:20];
    ok = 1'b1;
    case (opc)
      OPC_LUI: begin d.inst = INST_LUI; d.rd_need = 1'b1; d.imm = u_imm; end
      OPC_AUIPC: begin d.inst = INST_AUIPC; d.rd_need = 1'b1; d.imm = u_imm; end
      OPC_JAL: begin d.inst = INST_JAL; d.rd_need = 1'b1; d.imm = j_imm; end
      OPC_JALR: begin
        ok = f3 == 3'd0;
        d.inst = INST_JALR; d.rs1_need = 1'b1; d.rd_need = 1'b1; d.imm = i_imm;
      end
      OPC_BRANCH: begin
        ok = f3[2:1] != 2'b01;
        d.inst = INST_BEQ | fam; d.rs1_need = 1'b1; d.rs2_need = 1'b1; d.imm = b_imm;
      end
      OPC_LOAD: begin
        ok = f3 != 3'd3 && f3[2:1] != 2'b11;
        d.inst = INST_LB | fam; d.rs1_need = 1'b1; d.rd_need = 1'b1; d.mem_need = 1'b1; d.imm = i_imm;
      end
      OPC_STORE: begin
        ok = f3 < 3'd3;
        d.inst = INST_SB | fam; d.rs1_need = 1'b1; d.rs2_need = 1'b1; d.mem_need = 1'b1; d.imm = s_imm;
      end
      OPC_OPIMM: begin
        ok = f3 != 3'd5 || f7 == 7'h00 || alt;
        d.inst = f3 == 3'd5 && alt ? INST_SRAI : INST_ADDI | fam;
        d.rs1_need = 1'b1; d.rd_need = 1'b1; d.imm = i_imm;
      end
      OPC_OP: begin
        ok = f3 == 3'd0 || f3 == 3'd5 ? f7 == 7'h00 || alt : 1'b1;
        d.inst = f3 == 3'd0 && alt ? INST_SUB : f3 == 3'd5 && alt ? INST_SRA : INST_ADD | fam;
        d.rs1_need = 1'b1; d.rs2_need = 1'b1; d.rd_need = 1'b1;
      end
      default: ok = 1'b0;
    endcase
    if (!ok) begin
      d.inst = INST_ILLEGAL;
      d.rs1_need = 1'b0;
      d.rs2_need = 1'b0;
      d.rd_need = 1'b0;
      d.mem_need = 1'b0;
      d.imm = '0;
    end
    d.illegal = ~ok;
  end
  assign dec = d;
endmodule

// File: rtl/decode_queue.sv
// decode_queue: decodes fetched instructions on entry and buffers them in a DEPTH-entry circular queue
module decode_queue
  import decode_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ADDR_W = 32,
  parameter int IMM_W = 32
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              clear_in,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [31:0]       up_inst,
  input  logic [ADDR_W-1:0] up_npc,
  output logic              to_valid,
  input  logic              down_ready,
  output logic [INST_W-1:0] to_inst,
  output logic [ADDR_W-1:0] to_npc,
  output logic [REG_W-1:0]  to_rs1,
  output logic [REG_W-1:0]  to_rs2,
  output logic [REG_W-1:0]  to_rd,
  output logic              rs1_in_need,
  output logic              rs2_in_need,
  output logic              rd_in_need,
  output logic              mem_in_need,
  output logic [IMM_W-1:0]  to_imme,
  output logic              to_illegal
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  dec_t dec, h;
  dec_t mem [DEPTH];
  logic [ADDR_W-1:0] npc_mem [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;
  logic push, pop;
  decode_core u_core (.up_inst(up_inst), .dec(dec));
  assign up_ready = (count != CNT_W'(DEPTH)) & ~rst_in;
  assign to_valid = count != '0;
  assign push = rdy_in & ~clear_in & up_valid & up_ready;
  assign pop = rdy_in & ~clear_in & to_valid & down_ready;
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in || clear_in) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      head <= head + PTR_W'(pop);
      tail <= tail + PTR_W'(push);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end
  always_ff @(posedge clk_in) begin
    if (push) begin
      mem[tail] <= dec;
      npc_mem[tail] <= up_npc;
    end
  end
  // an empty queue presents all-zero outputs rather than stale storage
  assign h = to_valid ? mem[head] : '0;
  assign to_npc = to_valid ? npc_mem[head] : '0;
  assign to_inst = h.inst;
  assign to_rs1 = h.rs1;
  assign to_rs2 = h.rs2;
  assign to_rd = h.rd;
  assign rs1_in_need = h.rs1_need;
  assign rs2_in_need = h.rs2_need;
  assign rd_in_need = h.rd_need;
  assign mem_in_need = h.mem_need;
  assign to_imme = IMM_W'($signed(h.imm));
  assign to_illegal = h.illegal;
endmodule

// File: doc/decode_queue.md
Name: decode_queue

Overview:
- Parametrised successor of the combinational RV32I decode stage: decodes each fetched instruction on entry and buffers the decoded bundles in a DEPTH-entry circular queue.
- Sits between fetch and dispatch and decouples them with valid/ready handshakes on both sides.
- Adds behaviour the single-instruction decoder lacks: buffering, back-pressure, flush on mispredict, and an illegal-instruction flag.

Parameters:
- DEPTH, 4, number of queue entries; power of 2, at least 2.
- ADDR_W, 32, width of npc.
- IMM_W, 32, width of the immediate.

Ports:
- clk_in  in  1  clock
- rst_in  in  1  reset; asynchronous, active-high
- rdy_in  in  1  global enable; when 0, queue state is frozen
- clear_in  in  1  flush (branch mispredict)
- up_valid  in  1  fetch presents an instruction
- up_ready  out  1  queue can accept
- up_inst  in  32  raw instruction
- up_npc  in  ADDR_W  instruction pc/npc
- to_valid  out  1  head entry valid
- down_ready  in  1  dispatch accepts head
- to_inst  out  `InstBus  internal opcode code (`Inst*`)
- to_npc  out  ADDR_W  npc of the head entry
- to_rs1, to_rs2, to_rd  out  `RegBus  register indices, zero-extended from 5 bits
- rs1_in_need, rs2_in_need, rd_in_need, mem_in_need  out  1  operand and memory usage flags
- to_imme  out  IMM_W  sign/format-extended immediate
- to_illegal  out  1  head entry is an undecodable instruction

Behaviour:
- Reset (async, rst_in=1):
  - head=0, tail=0, count=0.
  - up_ready=0 while in reset, to_valid=0.
  - All to_* outputs and flags are 0. Entry storage is don't-care.
  - Reset mid-operation discards all entries immediately.
- Decode rules (combinational, on up_inst):
  - Formats: U/J/I/B/S immediates, exactly as in RV32I.
  - lui, auipc, jal: rd_need=1.
  - jalr: rs1_need, rd_need.
  - Branches: rs1_need, rs2_need.
  - Loads: rs1_need, rd_need, mem_need.
  - Stores: rs1_need, rs2_need, mem_need.
  - OP-IMM: rs1_need, rd_need.
  - OP: rs1_need, rs2_need, rd_need, imm=0.
  - rd/rs1/rs2 are always extracted from bits [11:7], [19:15], [24:20].
- Illegal encodings: any unknown opcode, funct3, or funct7 (for add/sub, srl/sra, srli/srai) sets illegal=1, inst code=0, and all need flags=0. The instruction is still enqueued.
- Enqueue (rising edge, rdy_in=1, clear_in=0, up_valid & up_ready):
  - Decoded bundle is written at tail; tail increments mod DEPTH.
- Dequeue (rdy_in=1, clear_in=0, to_valid & down_ready):
  - head increments mod DEPTH.
- Simultaneous enqueue and dequeue: both happen; count is unchanged.
- up_ready = (count != DEPTH) & ~rst_in. When full, enqueue is refused even if a dequeue occurs in the same cycle.
- to_valid = (count != 0). Head outputs are read combinationally from storage.
- Empty: every to_* output and flag is forced to 0.
- Latency: an instruction accepted at edge N is visible at the head after edge N if the queue was empty. Throughput is 1 per cycle each way.
- clear_in=1 at an edge: head=tail=count=0 regardless of rdy_in. Any same-cycle enqueue or dequeue is discarded. clear_in has priority over the handshake.
- rdy_in=0: no pointer or count change, outputs hold, up_ready remains as computed (the handshake is ignored).
- Pointers use $clog2(DEPTH) bits and wrap naturally. count uses $clog2(DEPTH)+1 bits.

Decomposition:
- Shared header constant.v already carries the `Inst*` codes, `InstBus`, `RegBus` and `ImmediateBus`. Add `InstIllegal` (=0) there.
- Sub-module decode_core is purely combinational: up_inst in, decoded bundle plus illegal out.
- decode_queue instantiates decode_core and owns the storage, pointers, and handshake.

Test Plan:
- Reset, then push lui x1,0x12345 (0x123450B7) with down_ready=0 → next cycle to_valid=1, to_rd=1, rd_in_need=1, to_imme=0x12345000, up_ready=1.
- Push addi x2,x1,-1 (0xFFF08113), beq x1,x2,8 (0x00208463), sw x2,4(x1) (0x0020A223), each dequeued in turn:
  - addi: imm 0xFFFFFFFF, rs1_need=1.
  - beq: imm 8, rs1/rs2_need=1, rd_need=0.
  - sw: imm 4, mem_in_need=1.
- Push 5 instructions with DEPTH=4 and down_ready=0 → up_ready=0 after the 4th, 5th not accepted. Then assert up_valid & down_ready in the same cycle while full → count stays 4-1=3 next cycle and the 5th is accepted the following cycle. Order is preserved and tail wrap is verified.
- Push 0xFFFFFFFF → to_illegal=1, to_inst=0, all need flags=0.
- Queue holding 3 entries, assert clear_in together with up_valid and down_ready → next cycle to_valid=0, count=0, to_* all 0.
- Hold rdy_in=0 with up_valid and down_ready set for 3 cycles → no change to contents or head outputs. Then assert rst_in asynchronously mid-cycle → to_valid drops immediately without a clock edge.
